// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute control unit driving the ALU, accumulator and carry register.
// Define SEQ_ZERO_JUMP_EN to enable the JZ/JNZ opcodes (0xC/0xD) that test acc_zero.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif
`ifndef ALU_AND
`define ALU_AND 3'd2
`endif
`ifndef ALU_OR
`define ALU_OR 3'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'd4
`endif
`ifndef ALU_NOT
`define ALU_NOT 3'd5
`endif
`ifndef ALU_LD
`define ALU_LD 3'd6
`endif

module alu_sequencer (
  input  logic        clk,
  input  logic        nReset,
  input  logic        run,
  input  logic [11:0] instr_in,
  input  logic        cy_in,
  input  logic        acc_zero,
  output logic [7:0]  pc_out,
  output logic [2:0]  alu_code,
  output logic [7:0]  r_out,
  output logic        ci_out,
  output logic        a_ce,
  output logic        cy_ce,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_XORI = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JNC  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hB;
`ifdef SEQ_ZERO_JUMP_EN
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JNZ  = 4'hD;
`endif
  localparam logic [3:0] OP_ADCI = 4'hE;

  typedef struct packed {
    logic [2:0] code;
    logic       a_en;
    logic       c_en;
    logic       use_cy;
  } dec_t;

  // NOP, jumps, HLT and unused opcodes fall through to "no strobes, LD code"
  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d.code   = `ALU_LD;
    d.a_en   = 1'b0;
    d.c_en   = 1'b0;
    d.use_cy = 1'b0;
    case (op)
      OP_LDI:  d.a_en = 1'b1;
      OP_ADDI: begin d.code = `ALU_ADD; d.a_en = 1'b1; d.c_en = 1'b1; end
      OP_SUBI: begin d.code = `ALU_SUB; d.a_en = 1'b1; d.c_en = 1'b1; end
      OP_ANDI: begin d.code = `ALU_AND; d.a_en = 1'b1; end
      OP_ORI:  begin d.code = `ALU_OR;  d.a_en = 1'b1; end
      OP_XORI: begin d.code = `ALU_XOR; d.a_en = 1'b1; end
      OP_NOT:  begin d.code = `ALU_NOT; d.a_en = 1'b1; end
      OP_ADCI: begin d.code = `ALU_ADD; d.a_en = 1'b1; d.c_en = 1'b1; d.use_cy = 1'b1; end
      default: d.code = `ALU_LD;
    endcase
    return d;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] pc_r, pc_s;
  logic [11:0] ir_r, ir_s;
  logic [2:0] code_r, code_s;
  logic [7:0] r_r, r_s;
  logic       ci_r, ci_s;
  logic       a_ce_r, a_ce_s;
  logic       cy_ce_r, cy_ce_s;
  logic       halted_r, halted_s;
  logic       take_s;
  dec_t       dec_s;

`ifndef SEQ_ZERO_JUMP_EN
  logic unused_acc_zero_s;
  assign unused_acc_zero_s = acc_zero;
`endif

  // Jump resolution on the instruction held in IR, using flags as seen during EXEC
  always_comb begin
    take_s = 1'b0;
    case (ir_r[11:8])
      OP_JMP:  take_s = 1'b1;
      OP_JC:   take_s = cy_in;
      OP_JNC:  take_s = ~cy_in;
`ifdef SEQ_ZERO_JUMP_EN
      OP_JZ:   take_s = acc_zero;
      OP_JNZ:  take_s = ~acc_zero;
`endif
      default: take_s = 1'b0;
    endcase
  end

  // Next state; control outputs for EXEC are prepared during FETCH so they leave a register
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    ir_s     = ir_r;
    code_s   = `ALU_LD;
    r_s      = 8'd0;
    ci_s     = 1'b0;
    a_ce_s   = 1'b0;
    cy_ce_s  = 1'b0;
    halted_s = halted_r;
    dec_s    = decode(instr_in[11:8]);
    case (state_r)
      IDLE: begin
        if (run) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        ir_s    = instr_in;
        pc_s    = pc_r + 8'd1;
        state_s = EXEC;
        code_s  = dec_s.code;
        r_s     = instr_in[7:0];
        a_ce_s  = dec_s.a_en;
        cy_ce_s = dec_s.c_en;
        // RegCY cannot change between FETCH and EXEC, so this equals cy_in during EXEC
        ci_s    = dec_s.use_cy & cy_in;
      end
      EXEC: begin
        if (ir_r[11:8] == OP_HLT) begin
          state_s  = HALT;
          halted_s = 1'b1;
        end else begin
          state_s = FETCH;
        end
        if (take_s) begin
          pc_s = ir_r[7:0];
        end else begin
          pc_s = pc_r;
        end
      end
      HALT: begin
        state_s  = HALT;
        halted_s = 1'b1;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, PC, IR and registered control outputs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r  <= IDLE;
      pc_r     <= 8'd0;
      ir_r     <= 12'd0;
      code_r   <= `ALU_LD;
      r_r      <= 8'd0;
      ci_r     <= 1'b0;
      a_ce_r   <= 1'b0;
      cy_ce_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      ir_r     <= ir_s;
      code_r   <= code_s;
      r_r      <= r_s;
      ci_r     <= ci_s;
      a_ce_r   <= a_ce_s;
      cy_ce_r  <= cy_ce_s;
      halted_r <= halted_s;
    end
  end

  assign pc_out   = pc_r;
  assign alu_code = code_r;
  assign r_out    = r_r;
  assign ci_out   = ci_r;
  assign a_ce     = a_ce_r;
  assign cy_ce    = cy_ce_r;
  assign halted   = halted_r;

endmodule
